cvp_apb_bridge: RTL and testbench

APB slave that fronts the CVP power-controller port. It converts 32-bit APB accesses from the host peripheral bus into single 64-bit `pwr_req`/`pwr_ack` transactions on the CVP interface, one at a time. It adds an ack timeout and error reporting. It sits directly upstream of the `cvp` block, in the `clk_cvp` domain.

---
 rtl/cvp_pkg.sv | 27 ++
 rtl/cvp_timeout_cnt.sv | 27 ++
 rtl/cvp_apb_bridge.sv | 114 +++++++++++
 tb/tb_cvp_apb_bridge.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cvp_pkg.sv
// Shared CVP definitions: bridge state encoding, bus geometry and the
// byte-lane steering used when a 32-bit APB access lands on the 64-bit port.
package cvp_pkg;

    localparam int CVP_ADDR_LSB = 3;
    localparam int CVP_DATA_W   = 64;
    localparam int CVP_BE_W     = 8;
    localparam int CVP_ADDR_W   = 32 - CVP_ADDR_LSB;

    typedef enum logic [1:0] {
        BR_IDLE,
        BR_REQ,
        BR_RESP,
        BR_DRAIN
    } cvp_br_state_e;

    // Reads always fetch the whole 32-bit half; writes forward pstrb as-is,
    // including an all-zero strobe.
    function automatic logic [CVP_BE_W-1:0] cvp_lane_be(input logic       hi,
                                                        input logic       wr,
                                                        input logic [3:0] strb);
        logic [3:0] b;
        b = wr ? strb : 4'hF;
        return hi ? {b, 4'h0} : {4'h0, b};
    endfunction

endpackage

// File: rtl/cvp_timeout_cnt.sv
// Ack timeout counter: cleared on request launch, counts each enabled cycle,
// and flags the cycle whose count would reach LIMIT.
module cvp_timeout_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk_cvp,
    input  logic rst_async_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [15:0] cnt;

    always_ff @(posedge clk_cvp or negedge rst_async_n) begin
        if (!rst_async_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 16'd1;
    end

    // Combinational so the FSM can leave REQ on the LIMIT-th waiting cycle.
    assign expired = en && (cnt == 16'(LIMIT - 1));

endmodule

// File: rtl/cvp_apb_bridge.sv
// APB slave turning single 32-bit accesses into one 64-bit pwr_req/pwr_ack
// transaction on the CVP port, with ack timeout and error counting.
module cvp_apb_bridge
    import cvp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                  clk_cvp,
    input  logic                  rst_async_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [31:0]           paddr,
    input  logic [31:0]           pwdata,
    input  logic [3:0]            pstrb,
    output logic                  pready,
    output logic [31:0]           prdata,
    output logic                  pslverr,
    output logic                  pwr_req,
    output logic [CVP_DATA_W-1:0] pwr_w_data,
    output logic [CVP_ADDR_W-1:0] pwr_addr,
    output logic [CVP_BE_W-1:0]   pwr_be,
    output logic                  pwr_wr_rd,
    input  logic                  pwr_ack,
    input  logic [CVP_DATA_W-1:0] pwr_r_data,
    input  logic                  pwr_error,
    output logic                  busy,
    output logic                  timeout_pulse,
    output logic [ERR_CNT_W-1:0]  err_count
);

    cvp_br_state_e        state;
    logic                 lane_hi;
    logic                 expired;
    logic [ERR_CNT_W-1:0] err_inc;
    logic                 unused_apb;

    // penable is irrelevant: the transfer is latched on the setup cycle.
    assign unused_apb = ^{paddr[1:0], penable};

    assign err_inc = (&err_count) ? err_count : err_count + ERR_CNT_W'(1);

    cvp_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
        .clk_cvp     (clk_cvp),
        .rst_async_n (rst_async_n),
        .clr         (state == BR_IDLE && psel),
        .en          (state == BR_REQ),
        .expired     (expired)
    );

    always_ff @(posedge clk_cvp or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state         <= BR_IDLE;
            lane_hi       <= 1'b0;
            pwr_req       <= 1'b0;
            pwr_wr_rd     <= 1'b0;
            pwr_addr      <= '0;
            pwr_w_data    <= '0;
            pwr_be        <= '0;
            pready        <= 1'b0;
            prdata        <= '0;
            pslverr       <= 1'b0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
            err_count     <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                BR_IDLE: if (psel) begin
                    state      <= BR_REQ;
                    busy       <= 1'b1;
                    pwr_req    <= 1'b1;
                    lane_hi    <= paddr[2];
                    pwr_addr   <= paddr[31:CVP_ADDR_LSB];
                    pwr_wr_rd  <= pwrite;
                    pwr_w_data <= {pwdata, pwdata};
                    pwr_be     <= cvp_lane_be(paddr[2], pwrite, pstrb);
                end
                // Ack is tested first so it wins a tie with the timeout.
                BR_REQ: if (pwr_ack) begin
                    state   <= BR_RESP;
                    pwr_req <= 1'b0;
                    pready  <= 1'b1;
                    pslverr <= pwr_error;
                    prdata  <= pwr_wr_rd ? 32'h0 :
                               (lane_hi ? pwr_r_data[63:32] : pwr_r_data[31:0]);
                    if (pwr_error)
                        err_count <= err_inc;
                end else if (expired) begin
                    state         <= BR_RESP;
                    pwr_req       <= 1'b0;
                    pready        <= 1'b1;
                    pslverr       <= 1'b1;
                    prdata        <= 32'h0;
                    timeout_pulse <= 1'b1;
                    err_count     <= err_inc;
                end
                BR_RESP: begin
                    state   <= BR_DRAIN;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                end
                // Hold off new work until CVP releases ack from the last one.
                BR_DRAIN: if (!pwr_ack) begin
                    state <= BR_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= BR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cvp_apb_bridge.sv
// Bench for cvp_apb_bridge: transfers are scheduled on an absolute cycle
// timeline from the protocol rules and the DUT is compared to it every cycle.
module tb_cvp_apb_bridge;

    localparam int T    = 16;
    localparam int EW   = 8;
    localparam int MAXC = 16384;

    logic        clk_cvp = 1'b0;
    logic        rst_async_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        pready, pslverr, pwr_req, pwr_wr_rd, busy, timeout_pulse;
    logic [31:0] prdata;
    logic [63:0] pwr_w_data;
    logic [28:0] pwr_addr;
    logic [7:0]  pwr_be;
    logic        pwr_ack = 1'b0, pwr_error = 1'b0;
    logic [63:0] pwr_r_data = '0;
    logic [EW-1:0] err_count;

    cvp_apb_bridge #(.TIMEOUT_CYCLES(T), .ERR_CNT_W(EW)) dut (
        .clk_cvp(clk_cvp), .rst_async_n(rst_async_n),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
        .pslverr(pslverr), .pwr_req(pwr_req), .pwr_w_data(pwr_w_data),
        .pwr_addr(pwr_addr), .pwr_be(pwr_be), .pwr_wr_rd(pwr_wr_rd),
        .pwr_ack(pwr_ack), .pwr_r_data(pwr_r_data), .pwr_error(pwr_error),
        .busy(busy), .timeout_pulse(timeout_pulse), .err_count(err_count)
    );

    always #5 clk_cvp = ~clk_cvp;

    // cyc = number of rising edges so far; at a falling edge we are "after edge cyc".
    int cyc = 0;
    always @(posedge clk_cvp) cyc <= cyc + 1;

    int n_checks = 0, n_errors = 0;

    // Expected timeline, indexed by cycle.
    bit exp_req[MAXC], exp_busy[MAXC], exp_rdy[MAXC], exp_tp[MAXC], exp_err[MAXC];
    bit ack_s[MAXC], err_s[MAXC];
    logic [28:0] e_addr;
    logic        e_wr;
    logic [63:0] e_wdata;
    logic [7:0]  e_be;
    logic [31:0] e_prdata;
    logic        e_err;
    logic [EW-1:0] mcnt = '0;
    int free = 0, last_idx = 0, last_stall = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare, then drive the CVP ack/error for the next edge.
    initial forever begin
        int k;
        @(negedge clk_cvp);
        k = cyc;
        if (k < MAXC) begin
            if (!rst_async_n) mcnt = '0;
            else if (exp_rdy[k] && exp_err[k] && mcnt != '1) mcnt = mcnt + EW'(1);
            chk("pwr_req", pwr_req, exp_req[k]);
            chk("busy", busy, exp_busy[k]);
            chk("pready", pready, exp_rdy[k]);
            chk("timeout_pulse", timeout_pulse, exp_tp[k]);
            chk("err_count", err_count, mcnt);
            if (exp_req[k]) begin
                chk("pwr_addr", pwr_addr, e_addr);
                chk("pwr_wr_rd", pwr_wr_rd, e_wr);
                chk("pwr_w_data", pwr_w_data, e_wdata);
                chk("pwr_be", pwr_be, e_be);
            end
            if (exp_rdy[k]) begin
                chk("prdata", prdata, e_prdata);
                chk("pslverr", pslverr, exp_err[k]);
            end
            pwr_ack   = ack_s[k];
            pwr_error = err_s[k];
        end
    end

    // One APB transfer; CVP acks d cycles after first sampling pwr_req (or never)
    // and keeps ack h extra cycles after it sees pwr_req fall.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int d, input bit noack,
                        input int h, input bit err, input logic [63:0] rdata);
        int c, a, idx;
        c   = cyc;
        a   = (c + 1 > free) ? c + 1 : free;
        idx = noack ? T : d + 2;
        if (noack) h = 0;
        last_idx   = idx;
        last_stall = a - (c + 1);
        e_addr   = addr[31:3];
        e_wr     = wr;
        e_wdata  = {wdata, wdata};
        e_be     = wr ? (addr[2] ? {strb, 4'h0} : {4'h0, strb}) : (addr[2] ? 8'hF0 : 8'h0F);
        e_prdata = (noack || wr) ? 32'h0 : (addr[2] ? rdata[63:32] : rdata[31:0]);
        e_err    = noack | err;
        if (a + idx + h + 4 < MAXC) begin
            for (int k = a; k < a + idx; k++) exp_req[k] = 1'b1;
            for (int k = a; k <= a + idx + 1 + h; k++) exp_busy[k] = 1'b1;
            exp_rdy[a+idx] = 1'b1;
            exp_err[a+idx] = e_err;
            exp_tp[a+idx]  = noack;
            if (!noack)
                for (int k = a + d + 1; k <= a + idx + h; k++) begin
                    ack_s[k] = 1'b1;
                    err_s[k] = err;
                end
        end
        free = a + idx + 3 + h;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wdata; pstrb = strb; pwr_r_data = rdata;
        @(negedge clk_cvp);
        penable = 1'b1;
        while (cyc < a + idx + 1) @(negedge clk_cvp);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_cvp);
    endtask

    initial begin
        int c, a;
        logic [31:0] ad;

        idle(2);
        chk("reset pwr_addr", pwr_addr, 29'h0);
        chk("reset pwr_w_data", pwr_w_data, 64'h0);
        chk("reset pwr_be", pwr_be, 8'h0);
        chk("reset pwr_wr_rd", pwr_wr_rd, 1'b0);
        chk("reset prdata", prdata, 32'h0);
        #2 rst_async_n = 1'b1;
        idle(2);

        xfer(1, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 64'h0);
        chk("pin write addr", e_addr, 29'h20);
        chk("pin write be", e_be, 8'hF0);
        chk("pin write data", e_wdata, 64'hDEADBEEF_DEADBEEF);
        chk("pin latency", last_idx + 2, 4);
        idle(2);

        xfer(0, 32'h0000_0104, 32'h0, 4'h0, 0, 0, 0, 0, 64'hDEADBEEF_00000000);
        chk("pin read be", e_be, 8'hF0);
        chk("pin read prdata", e_prdata, 32'hDEAD_BEEF);
        xfer(1, 32'h0000_0010, 32'h1234_5678, 4'h0, 2, 0, 0, 0, 64'h0);
        chk("pin zero strobe be", e_be, 8'h00);
        idle(1);

        xfer(0, 32'h0000_0200, 32'h0, 4'h0, 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("pin timeout idx", last_idx, T);
        chk("pin timeout prdata", e_prdata, 32'h0);
        idle(3);
        chk("err_count after timeout", err_count, 8'd1);

        // Ack exactly at the timeout limit wins.
        xfer(0, 32'h0000_0008, 32'h0, 4'h0, T - 2, 0, 0, 0, 64'h0123_4567_89AB_CDEF);
        chk("pin tie idx", last_idx, T);
        chk("pin tie prdata", e_prdata, 32'h89AB_CDEF);

        // Ack held long after being seen: the next psel stalls in DRAIN.
        xfer(1, 32'h0000_0040, 32'hCAFE_F00D, 4'h3, 1, 0, 5, 0, 64'h0);
        xfer(0, 32'h0000_0044, 32'h0, 4'h0, 0, 0, 0, 0, 64'hA5A5_0000_5A5A_0000);
        chk("pin drain stall", last_stall, 6);
        idle(3);

        for (int i = 0; i < 60; i++) begin
            ad = $urandom;
            xfer(1'($urandom_range(0, 1)), ad, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, T - 2), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                 {$urandom, $urandom});
            idle($urandom_range(0, 2));
        end

        for (int i = 0; i < 256; i++)
            xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'hF,
                 $urandom_range(0, 3), 0, 0, 1, {$urandom, $urandom});
        idle(3);
        chk("err_count saturated", err_count, 8'hFF);

        // Reset while in REQ.
        idle(2);
        c = cyc;
        a = c + 1;
        e_addr = 29'h1; e_wr = 1'b1; e_wdata = {2{32'h5555_AAAA}}; e_be = 8'h0F;
        for (int k = a; k <= a + 2; k++) begin
            exp_req[k]  = 1'b1;
            exp_busy[k] = 1'b1;
        end
        psel = 1'b1; pwrite = 1'b1; paddr = 32'h0000_0008; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
        idle(3);
        #2 rst_async_n = 1'b0;
        #1;
        chk("async reset pwr_req", pwr_req, 1'b0);
        chk("async reset busy", busy, 1'b0);
        chk("async reset err_count", err_count, 8'h0);
        psel = 1'b0;
        idle(2);
        #2 rst_async_n = 1'b1;
        free = 0;
        idle(1);
        xfer(1, 32'h0000_0104, 32'h0BAD_F00D, 4'hC, 1, 0, 1, 0, 64'h0);
        xfer(0, 32'h0000_0100, 32'h0, 4'h0, 3, 0, 0, 0, 64'h1111_2222_3333_4444);
        chk("pin post-reset prdata", e_prdata, 32'h3333_4444);
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
